carry_lookahead_subtractor_pipe: RTL

// - Pipelined unsigned/two's-complement subtractor built from carry-lookahead groups.

---
 rtl/carry_lookahead_subtractor_pipe.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/carry_lookahead_subtractor_pipe.sv
// Two-stage pipelined subtractor (diff = a + ~b + ~bin) built from GROUP-bit lookahead groups.
// Optional unsigned floor clamp of diff on borrow when SUB_SATURATE_EN is defined.
module carry_lookahead_subtractor_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int HALF = WIDTH / 2;
    localparam int NGRP = HALF / GROUP;

    // Adds one half: every carry inside a group is a flat sum of products of the
    // group's g/p terms and the group carry-in; only group carries ripple.
    function automatic logic [HALF:0] cla_half(
        input logic [HALF-1:0] x,
        input logic [HALF-1:0] y,
        input logic            cin
    );
        logic [HALF-1:0] g;
        logic [HALF-1:0] p;
        logic [HALF-1:0] s;
        logic [GROUP:0]  c;
        logic            c_grp;
        logic            term;
        // NOTE: blocking assignments are right here; this is pure combinational
        // evaluation, whereas clocked state below uses non-blocking assignments.
        g     = x & y;
        p     = x ^ y;
        s     = '0;
        c     = '0;
        term  = 1'b0;
        c_grp = cin;
        for (int k = 0; k < NGRP; k++) begin
            for (int j = 0; j <= GROUP; j++) begin
                c[j] = c_grp;
                for (int m = 0; m < j; m++) begin
                    c[j] = c[j] & p[k*GROUP+m];
                end
                for (int m = 0; m < j; m++) begin
                    term = g[k*GROUP+m];
                    for (int n = m + 1; n < j; n++) begin
                        term = term & p[k*GROUP+n];
                    end
                    c[j] = c[j] | term;
                end
            end
            for (int j = 0; j < GROUP; j++) begin
                s[k*GROUP+j] = p[k*GROUP+j] ^ c[j];
            end
            c_grp = c[GROUP];
        end
        return {c_grp, s};
    endfunction

    logic adv1;
    logic adv2;

    logic            s1_valid;
    logic [HALF-1:0] s1_lo;
    logic            s1_c;
    logic [HALF-1:0] s1_a_hi;
    logic [HALF-1:0] s1_nb_hi;
    logic            s1_a_msb;
    logic            s1_b_msb;

    logic             s2_valid;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;

    logic [HALF:0]    lo_sum;
    logic [HALF:0]    hi_sum;
    logic [WIDTH-1:0] diff_full;
    logic [WIDTH-1:0] diff_s2;
    logic             borrow_s2;
    logic             ovf_s2;

    assign adv2     = !s2_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1 && !rst;

    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    always_comb begin
        lo_sum    = cla_half(a[HALF-1:0], ~b[HALF-1:0], ~bin);
        hi_sum    = cla_half(s1_a_hi, s1_nb_hi, s1_c);
        diff_full = {hi_sum[HALF-1:0], s1_lo};
        borrow_s2 = ~hi_sum[HALF];
        ovf_s2    = (s1_a_msb != s1_b_msb) && (diff_full[WIDTH-1] != s1_a_msb);
`ifdef SUB_SATURATE_EN
        diff_s2   = borrow_s2 ? '0 : diff_full;
`else
        diff_s2   = diff_full;
`endif
    end

    // NOTE: S1 payload needs no reset; s1_valid alone decides whether it is used.
    always_ff @(posedge clk) begin
        if (adv1) begin
            s1_lo    <= lo_sum[HALF-1:0];
            s1_c     <= lo_sum[HALF];
            s1_a_hi  <= a[WIDTH-1:HALF];
            s1_nb_hi <= ~b[WIDTH-1:HALF];
            s1_a_msb <= a[WIDTH-1];
            s1_b_msb <= b[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid && in_ready;
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                diff_q   <= diff_s2;
                bout_q   <= borrow_s2;
                ovf_q    <= ovf_s2;
            end
        end
    end

    // Outputs read as idle during the reset cycle itself, not just after the edge.
    assign out_valid = s2_valid && !rst;
    assign diff      = rst ? '0 : diff_q;
    assign bout      = bout_q && !rst;
    assign ovf       = ovf_q && !rst;

endmodule
